// File: rtl/des_trace_sequencer.sv
// Campaign controller for the DES core: launches LFSR plaintexts, frames each
// encryption with a scope trigger window, detects timeouts and counts runs.
module des_trace_sequencer #(
    parameter int unsigned PRE_CYCLES     = 2,
    parameter int unsigned POST_CYCLES    = 3,
    parameter int unsigned GAP_CYCLES     = 4,
    parameter int unsigned TIMEOUT_CYCLES = 16,
    parameter int unsigned NUM_RUNS       = 0,
    parameter logic [63:0] PT_SEED        = 64'h1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    output logic        des_start,
    output logic [63:0] des_pt,
    input  logic        des_done,
    input  logic [63:0] des_ct,
    output logic        trigger,
    output logic        busy,
    output logic [15:0] run_count,
    output logic [63:0] last_ct,
    output logic        timeout_err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRE,
        S_WAIT,
        S_POST,
        S_GAP,
        S_DONE,
        S_ERR
    } state_t;

    // An all-zero LFSR would lock up, so a zero seed is promoted to 1.
    localparam logic [63:0] SEED = (PT_SEED == 64'h0) ? 64'h1 : PT_SEED;

    state_t      state;
    logic [31:0] cnt;

    function automatic logic [63:0] lfsr_next(input logic [63:0] v);
        return {v[62:0], v[63] ^ v[62] ^ v[60] ^ v[59]};
    endfunction

    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= S_IDLE;
            cnt         <= '0;
            des_start   <= 1'b0;
            des_pt      <= SEED;
            trigger     <= 1'b0;
            busy        <= 1'b0;
            run_count   <= '0;
            last_ct     <= '0;
            timeout_err <= 1'b0;
        end else begin
            des_start <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (enable) begin
                        state   <= S_PRE;
                        trigger <= 1'b1;
                        busy    <= 1'b1;
                        cnt     <= '0;
                    end
                end
                S_PRE: begin
                    if (cnt == PRE_CYCLES - 1) begin
                        state     <= S_WAIT;
                        des_start <= 1'b1;
                        cnt       <= '0;
                    end else begin
                        cnt <= cnt + 32'd1;
                    end
                end
                S_WAIT: begin
                    // des_done is checked first so it wins over a coincident timeout.
                    if (des_done) begin
                        state   <= S_POST;
                        last_ct <= des_ct;
                        des_pt  <= lfsr_next(des_pt);
                        cnt     <= '0;
                        if (run_count != '1) begin
                            run_count <= run_count + 16'd1;
                        end
                    end else if (cnt == TIMEOUT_CYCLES - 1) begin
                        state       <= S_ERR;
                        trigger     <= 1'b0;
                        busy        <= 1'b0;
                        timeout_err <= 1'b1;
                    end else begin
                        cnt <= cnt + 32'd1;
                    end
                end
                S_POST: begin
                    if (cnt == POST_CYCLES - 1) begin
                        state   <= S_GAP;
                        trigger <= 1'b0;
                        cnt     <= '0;
                    end else begin
                        cnt <= cnt + 32'd1;
                    end
                end
                S_GAP: begin
                    if (cnt == GAP_CYCLES - 1) begin
                        cnt <= '0;
                        if (NUM_RUNS != 0 && 32'(run_count) == NUM_RUNS) begin
                            state <= S_DONE;
                            busy  <= 1'b0;
                        end else if (enable) begin
                            state   <= S_PRE;
                            trigger <= 1'b1;
                        end else begin
                            state <= S_IDLE;
                            busy  <= 1'b0;
                        end
                    end else begin
                        cnt <= cnt + 32'd1;
                    end
                end
                S_DONE: begin
                    if (!enable) begin
                        state     <= S_IDLE;
                        run_count <= '0;
                    end
                end
                S_ERR: begin
                    trigger <= 1'b0;
                    busy    <= 1'b0;
                end
                default: begin
                    state   <= S_IDLE;
                    trigger <= 1'b0;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_des_trace_sequencer.sv
// Self-checking bench for des_trace_sequencer: behavioural DES core responder,
// plaintext/ciphertext scoreboard queues and a per-run expectation table.
module tb_des_trace_sequencer;

    localparam int unsigned NUM_RUNS = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        enable = 1'b0;
    logic        des_start;
    logic [63:0] des_pt;
    logic        des_done;
    logic [63:0] des_ct;
    logic        trigger;
    logic        busy;
    logic [15:0] run_count;
    logic [63:0] last_ct;
    logic        timeout_err;

    logic        core_done = 1'b0;
    logic [63:0] core_ct = '0;
    logic        stray_done = 1'b0;
    logic [63:0] stray_ct = '0;
    logic        core_answer = 1'b1;
    int          core_lat = 5;   // des_done lands in the core_lat-th WAIT cycle
    logic [63:0] last_exp = '0;

    logic [63:0] pt_q[$];
    logic [63:0] ct_q[$];

    int errors = 0;
    int checks = 0;

    assign des_done = core_done | stray_done;
    assign des_ct   = core_done ? core_ct : stray_ct;

    des_trace_sequencer #(
        .PRE_CYCLES(2),
        .POST_CYCLES(3),
        .GAP_CYCLES(4),
        .TIMEOUT_CYCLES(16),
        .NUM_RUNS(NUM_RUNS),
        .PT_SEED(64'h1)
    ) dut (
        .clk(clk),
        .rst(rst),
        .enable(enable),
        .des_start(des_start),
        .des_pt(des_pt),
        .des_done(des_done),
        .des_ct(des_ct),
        .trigger(trigger),
        .busy(busy),
        .run_count(run_count),
        .last_ct(last_ct),
        .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // DES core model: checks the plaintext at each start and answers with a
    // keyed-looking function of it.
    initial begin
        logic [63:0] ct;
        forever begin
            @(negedge clk);
            if (des_start && rst) begin
                if (pt_q.size() == 0) check("unexpected_des_start", 64'(des_start), 64'h0);
                else check("des_pt", des_pt, pt_q.pop_front());
                if (core_answer) begin
                    repeat (core_lat - 1) @(negedge clk);
                    ct = {des_pt[31:0], des_pt[63:32]} ^ 64'h0123_4567_89AB_CDEF;
                    ct_q.push_back(ct);
                    last_exp  = ct;
                    core_ct   = ct;
                    core_done = 1'b1;
                    @(negedge clk);
                    core_done = 1'b0;
                    core_ct   = 64'(($urandom() << 32) | $urandom());
                    check("last_ct", last_ct, ct_q.pop_front());
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic wait_rise(input string tag, output int waited);
        waited = 0;
        while (!trigger && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        check({tag, "_rise"}, 64'(trigger), 64'h1);
    endtask

    // Called at the first negedge with trigger high; returns at the first low one.
    task automatic measure_window(input string tag, input int exp_len);
        int hi = 0;
        int sd = -1;
        while (trigger && hi < 300) begin
            if (des_start && sd < 0) sd = hi;
            @(negedge clk);
            hi++;
        end
        check({tag, "_start_delay"}, 64'(sd), 64'd2);
        check({tag, "_trig_len"}, 64'(hi), 64'(exp_len));
    endtask

    task automatic no_activity(input string tag, input int n);
        int seen = 0;
        for (int i = 0; i < n; i++) begin
            if (trigger || des_start) seen++;
            @(negedge clk);
        end
        check({tag, "_quiet"}, 64'(seen), 64'h0);
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_des_start"}, 64'(des_start), 64'h0);
        check({tag, "_des_pt"}, des_pt, 64'h1);
        check({tag, "_trigger"}, 64'(trigger), 64'h0);
        check({tag, "_busy"}, 64'(busy), 64'h0);
        check({tag, "_run_count"}, 64'(run_count), 64'h0);
        check({tag, "_timeout_err"}, 64'(timeout_err), 64'h0);
    endtask

    typedef struct {
        logic        en;
        logic [63:0] pt;
        int          trig_len;
        logic [15:0] rc;
    } vec_t;

    initial begin
        vec_t vecs[4];
        int   w;
        int   k;

        vecs[0] = '{en: 1'b1, pt: 64'h1, trig_len: 10, rc: 16'd1};
        vecs[1] = '{en: 1'b1, pt: 64'h2, trig_len: 10, rc: 16'd2};
        vecs[2] = '{en: 1'b1, pt: 64'h4, trig_len: 10, rc: 16'd3};
        vecs[3] = '{en: 1'b1, pt: 64'h8, trig_len: 10, rc: 16'd1};

        // Reset state
        repeat (3) @(negedge clk);
        check_reset_state("reset");
        check("reset_last_ct", last_ct, 64'h0);
        rst = 1'b1;

        // Three-run campaign with enable held
        for (int i = 0; i < 3; i++) pt_q.push_back(vecs[i].pt);
        for (int i = 0; i < 3; i++) begin
            enable = vecs[i].en;
            wait_rise($sformatf("run%0d", i), w);
            if (i > 0) check($sformatf("run%0d_gap", i), 64'(w), 64'd4);
            measure_window($sformatf("run%0d", i), vecs[i].trig_len);
            check($sformatf("run%0d_run_count", i), 64'(run_count), 64'(vecs[i].rc));
            check($sformatf("run%0d_busy_gap", i), 64'(busy), 64'h1);
        end
        repeat (4) @(negedge clk);
        check("done_busy", 64'(busy), 64'h0);
        check("done_run_count", 64'(run_count), 64'd3);
        no_activity("done", 10);

        // Drop and reassert enable: counter cleared, LFSR continues at 8
        enable = 1'b0;
        repeat (2) @(negedge clk);
        check("rearm_run_count", 64'(run_count), 64'h0);
        check("rearm_des_pt", des_pt, 64'h8);
        pt_q.push_back(vecs[3].pt);
        enable = vecs[3].en;
        wait_rise("run3", w);
        measure_window("run3", vecs[3].trig_len);
        check("run3_run_count", 64'(run_count), 64'(vecs[3].rc));

        // Timeout: core stays silent on the next run
        core_answer = 1'b0;
        pt_q.push_back(64'h10);
        wait_rise("to", w);
        check("to_gap", 64'(w), 64'd4);
        k = 0;
        while (!des_start && k < 20) begin @(negedge clk); k++; end
        check("to_start_seen", 64'(des_start), 64'h1);
        k = 0;
        while (!timeout_err && k < 40) begin @(negedge clk); k++; end
        check("to_latency", 64'(k), 64'd16);
        check("to_trigger", 64'(trigger), 64'h0);
        check("to_busy", 64'(busy), 64'h0);
        no_activity("err", 30);
        check("to_sticky", 64'(timeout_err), 64'h1);

        // Reset out of ERR, then a single-cycle enable pulse
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        check_reset_state("err_reset");
        core_answer = 1'b1;
        pt_q.push_back(64'h1);
        enable = 1'b1;
        @(negedge clk);
        enable = 1'b0;
        wait_rise("pulse", w);
        measure_window("pulse", 10);
        check("pulse_run_count", 64'(run_count), 64'd1);
        check("pulse_last_ct", last_ct, last_exp);
        repeat (4) @(negedge clk);
        check("pulse_idle_busy", 64'(busy), 64'h0);
        no_activity("pulse_idle", 10);

        // Stray des_done in IDLE
        stray_ct = 64'hDEAD_BEEF_0BAD_F00D;
        stray_done = 1'b1;
        @(negedge clk);
        stray_done = 1'b0;
        @(negedge clk);
        check("stray_idle_run_count", 64'(run_count), 64'd1);
        check("stray_idle_last_ct", last_ct, last_exp);
        check("stray_idle_des_pt", des_pt, 64'h2);

        // Stray des_done in GAP
        pt_q.push_back(64'h2);
        enable = 1'b1;
        @(negedge clk);
        enable = 1'b0;
        wait_rise("gaprun", w);
        measure_window("gaprun", 10);
        stray_ct = 64'hFFFF_0000_FFFF_0000;
        stray_done = 1'b1;
        @(negedge clk);
        stray_done = 1'b0;
        repeat (4) @(negedge clk);
        check("stray_gap_run_count", 64'(run_count), 64'd2);
        check("stray_gap_last_ct", last_ct, last_exp);
        check("stray_gap_des_pt", des_pt, 64'h4);
        check("stray_gap_busy", 64'(busy), 64'h0);

        // des_done in the final timeout cycle beats the timeout
        core_lat = 16;
        pt_q.push_back(64'h4);
        enable = 1'b1;
        @(negedge clk);
        enable = 1'b0;
        wait_rise("edge", w);
        measure_window("edge", 21);
        check("edge_timeout_err", 64'(timeout_err), 64'h0);
        check("edge_run_count", 64'(run_count), 64'd3);
        core_lat = 5;
        repeat (6) @(negedge clk);
        check("edge_done_cleared", 64'(run_count), 64'h0);

        // Reset in the middle of WAIT
        core_answer = 1'b0;
        pt_q.push_back(64'h8);
        enable = 1'b1;
        @(negedge clk);
        enable = 1'b0;
        k = 0;
        while (!des_start && k < 20) begin @(negedge clk); k++; end
        check("midrst_start_seen", 64'(des_start), 64'h1);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_reset_state("midrst");
        rst = 1'b1;
        no_activity("midrst_idle", 20);
        core_answer = 1'b1;

        check("pt_queue_drained", 64'(pt_q.size()), 64'h0);
        check("ct_queue_drained", 64'(ct_q.size()), 64'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
